mmio_timer_array: RTL and testbench
===================================

Name: mmio_timer_array

Overview:
- Memory-mapped multi-channel timer peripheral on the CPU data bus; the Mmu decodes its window and drives `sel`.
- Generalises the single free-running microsecond Timer:
  - NUM_CH independent channels;
  - per-channel compare match, one-shot or auto-reload mode, sticky pending flags;
  - one combined interrupt line.
- One shared prescaler generates the count tick. Single clock domain.

Parameters:
- NUM_CH, 4, number of timer channels (1..16)
- CNT_WIDTH, 32, counter/compare width in bits (8..32); narrower values zero-extended on read, upper din bits ignored on write
- PRESCALE, 50, clock cycles per count tick (>=1); 50 gives 1 MHz at a 50 MHz clock

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sel  in  1  window select from Mmu
- we  in  1  write strobe (acts only with sel)
- re  in  1  read strobe (acts only with sel)
- addr  in  32  byte address; only addr[7:2] decoded
- din  in  32  write data
- dout  out  32  registered read data
- irq  out  1  OR over channels of (pending & irq_en)

Behaviour:
- Address decode:
  - ch = addr[7:4], reg = addr[3:2].
  - reg 0 CTRL: bit0 en, bit1 autoreload, bit2 irq_en; other bits read 0.
  - reg 1 COUNT: R/W.
  - reg 2 COMPARE: R/W.
  - reg 3 STATUS: bit0 pending; write 1 to clear, write 0 no effect.
  - ch >= NUM_CH: reads return 0, writes ignored.
- Reset (async, immediate, including mid-count): prescaler=0, all CTRL/COUNT/COMPARE/pending=0, dout=0, irq=0.
- Prescaler:
  - free-running 0..PRESCALE-1.
  - tick=1 for one cycle when prescaler==PRESCALE-1, then wraps to 0.
  - PRESCALE=1 gives tick every cycle.
- Per channel, on a cycle with tick && en:
  - COUNT==COMPARE: pending<=1.
    - autoreload=1: COUNT<=0, en stays 1.
    - autoreload=0 (one-shot): COUNT<=0, en<=0.
  - otherwise COUNT<=COUNT+1, modulo 2^CNT_WIDTH (wraps past all-ones to 0 without setting pending).
- Without tick, or with en=0: COUNT holds.
- Bus write (sel&we) in same cycle as tick update to the same channel:
  - write to COUNT or CTRL wins over the tick update.
  - write to COMPARE takes effect; that cycle's match uses the old COMPARE.
- Write-1-to-clear STATUS in same cycle as a match set: set wins, pending stays 1.
- Read: on sel&re, dout <= addressed register at the next rising edge (latency 1). Otherwise dout holds its last value.
- Read and write to the same register in the same cycle: dout returns the pre-write value.
- Reads have no side effects.
- irq is registered: irq <= |(pending & irq_en) each cycle. It therefore rises one cycle after pending sets and falls one cycle after the clear.

Test Plan (NUM_CH=2, CNT_WIDTH=32, PRESCALE=2 unless stated):
- Reset then read all 8 regs:
  - every dout=0, irq=0.
  - read of ch 3 (addr 0x30): dout=0.
- Ch0 auto-reload: COMPARE=3, CTRL=0x7.
  - COUNT walks 0,1,2,3 every 2 cycles, then returns to 0 with pending=1.
  - irq=1 one cycle later.
  - write STATUS=1: pending=0, irq falls next cycle; counting continues.
- Ch1 one-shot: COMPARE=2, CTRL=0x1.
  - after 3 ticks: pending=1, COUNT=0, CTRL reads 0x0.
  - irq stays 0 (irq_en=0).
  - COUNT stays 0 for 20 further cycles.
- Wrap, CNT_WIDTH=8: COMPARE=0x05, write COUNT=0xFE, en=1.
  - COUNT sequence FE, FF, 00, …, 05.
  - pending set only at 05.
- Collisions (PRESCALE=1):
  - write COUNT=0x10 on a tick cycle: reads 0x10.
  - STATUS clear on the match cycle: pending remains 1.
- Async reset asserted mid-count (COUNT=0x1234) between edges:
  - all outputs and registers are 0 before the next edge.
  - counting stays stopped after reset is released.

Source files
------------

// File: rtl/mmio_timer_array.sv
// Multi-channel memory-mapped timer: shared prescaler tick, per-channel counter with
// compare match, one-shot or auto-reload, sticky pending flag and a combined irq.
module mmio_timer_array #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32,
    parameter int PRESCALE  = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]      PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]      PS_ONE  = PS_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    logic [PS_W-1:0]   prescale_reg;
    logic              tick;
    logic [3:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic              wr_en;
    logic [NUM_CH-1:0] pending_vec;
    logic [NUM_CH-1:0] irq_en_vec;
    logic [31:0]       ch_rd [NUM_CH];
    logic [31:0]       rd_data;
    logic              unused_bits;

    assign ch_sel      = addr[7:4];
    assign reg_sel     = addr[3:2];
    assign wr_en       = sel & we;
    assign tick        = (prescale_reg == PS_LAST);
    assign unused_bits = ^{addr[31:8], addr[1:0], din};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescale_reg <= '0;
        end else if (tick) begin
            prescale_reg <= '0;
        end else begin
            prescale_reg <= prescale_reg + PS_ONE;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic                 en_reg;
            logic                 autoreload_reg;
            logic                 irq_en_reg;
            logic                 pending_reg;
            logic [CNT_WIDTH-1:0] count_reg;
            logic [CNT_WIDTH-1:0] compare_reg;
            logic                 hit;
            logic                 match;

            assign hit   = wr_en && (ch_sel == 4'(gi));
            assign match = tick && en_reg && (count_reg == compare_reg);

            // Later assignments win: a match beats a clear, a bus write beats the tick update.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    en_reg         <= 1'b0;
                    autoreload_reg <= 1'b0;
                    irq_en_reg     <= 1'b0;
                    pending_reg    <= 1'b0;
                    count_reg      <= '0;
                    compare_reg    <= '0;
                end else begin
                    if (hit && reg_sel == REG_STATUS && din[0]) begin
                        pending_reg <= 1'b0;
                    end
                    if (match) begin
                        pending_reg <= 1'b1;
                    end
                    if (tick && en_reg) begin
                        if (match) begin
                            count_reg <= '0;
                            en_reg    <= autoreload_reg;
                        end else begin
                            count_reg <= count_reg + CNT_ONE;
                        end
                    end
                    if (hit && reg_sel == REG_CTRL) begin
                        en_reg         <= din[0];
                        autoreload_reg <= din[1];
                        irq_en_reg     <= din[2];
                    end
                    if (hit && reg_sel == REG_COUNT) begin
                        count_reg <= din[CNT_WIDTH-1:0];
                    end
                    if (hit && reg_sel == REG_COMPARE) begin
                        compare_reg <= din[CNT_WIDTH-1:0];
                    end
                end
            end

            assign ch_rd[gi] = (reg_sel == REG_CTRL)    ? {29'd0, irq_en_reg, autoreload_reg, en_reg} :
                               (reg_sel == REG_COUNT)   ? 32'(count_reg) :
                               (reg_sel == REG_COMPARE) ? 32'(compare_reg) :
                                                          {31'd0, pending_reg};
            assign pending_vec[gi] = pending_reg;
            assign irq_en_vec[gi]  = irq_en_reg;
        end
    endgenerate

    // Channels beyond NUM_CH never match and read back as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 4'(i)) begin
                rd_data = ch_rd[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout <= '0;
            irq  <= 1'b0;
        end else begin
            if (sel && re) begin
                dout <= rd_data;
            end
            irq <= |(pending_vec & irq_en_vec);
        end
    end

endmodule

// File: tb/tb_mmio_timer_array.sv
// Drives two timer configurations (32-bit/prescale 2 and 8-bit/prescale 1) from one bus
// and scores both against a behavioural register-level model.
module tb_mmio_timer_array;

    localparam int NCH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel, we, re;
    logic [31:0] addr, din;
    logic [31:0] dout0, dout1;
    logic        irq0, irq1;

    always #5 clock = ~clock;

    mmio_timer_array #(.NUM_CH(NCH), .CNT_WIDTH(32), .PRESCALE(2)) u_dut0 (
        .clock(clock), .reset(reset), .sel(sel), .we(we), .re(re),
        .addr(addr), .din(din), .dout(dout0), .irq(irq0)
    );

    mmio_timer_array #(.NUM_CH(NCH), .CNT_WIDTH(8), .PRESCALE(1)) u_dut1 (
        .clock(clock), .reset(reset), .sel(sel), .we(we), .re(re),
        .addr(addr), .din(din), .dout(dout1), .irq(irq1)
    );

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] a;
    } exp_t;

    exp_t   exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    event   rst_chk_ev;

    // Reference model: plain register state per instance and channel.
    bit     m_en  [2][NCH];
    bit     m_ar  [2][NCH];
    bit     m_ie  [2][NCH];
    bit     m_pd  [2][NCH];
    longint m_cnt [2][NCH];
    longint m_cmp [2][NCH];
    int     m_ps  [2];
    bit     m_irq [2];

    function automatic int ps_of(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic longint mask_of(int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'hFF;
    endfunction

    function automatic logic [31:0] mread(int k, int c, int r);
        if (c >= NCH) return 32'd0;
        case (r)
            0:       return {29'd0, m_ie[k][c], m_ar[k][c], m_en[k][c]};
            1:       return 32'(m_cnt[k][c]);
            2:       return 32'(m_cmp[k][c]);
            default: return {31'd0, m_pd[k][c]};
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_ps[k]  = 0;
            m_irq[k] = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                m_en[k][c] = 0; m_ar[k][c] = 0; m_ie[k][c] = 0; m_pd[k][c] = 0;
                m_cnt[k][c] = 0; m_cmp[k][c] = 0;
            end
        end
    endtask

    task automatic model_step();
        exp_t        e;
        int          c, r;
        bit          tk, match;
        logic [31:0] rv;
        c = int'(addr[7:4]);
        r = int'(addr[3:2]);
        e.a = addr;
        for (int k = 0; k < 2; k++) begin
            rv = mread(k, c, r);
            if (k == 0) e.d0 = rv; else e.d1 = rv;
            m_irq[k] = 1'b0;
            for (int ch = 0; ch < NCH; ch++)
                if (m_pd[k][ch] && m_ie[k][ch]) m_irq[k] = 1'b1;
            tk = (m_ps[k] == ps_of(k) - 1);
            m_ps[k] = (m_ps[k] + 1) % ps_of(k);
            for (int ch = 0; ch < NCH; ch++) begin
                match = tk && m_en[k][ch] && (m_cnt[k][ch] == m_cmp[k][ch]);
                if (tk && m_en[k][ch]) begin
                    if (match) begin
                        m_pd[k][ch]  = 1;
                        m_cnt[k][ch] = 0;
                        if (!m_ar[k][ch]) m_en[k][ch] = 0;
                    end else begin
                        m_cnt[k][ch] = (m_cnt[k][ch] + 1) & mask_of(k);
                    end
                end
                if (sel && we && c == ch) begin
                    case (r)
                        0: begin m_en[k][ch] = din[0]; m_ar[k][ch] = din[1]; m_ie[k][ch] = din[2]; end
                        1: m_cnt[k][ch] = longint'(din) & mask_of(k);
                        2: m_cmp[k][ch] = longint'(din) & mask_of(k);
                        default: if (din[0] && !match) m_pd[k][ch] = 0;
                    endcase
                end
            end
        end
        if (sel && re) exp_q.push_back(e);
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                model_clear();
                exp_q.delete();
            end else begin
                model_step();
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Monitor: pops read results, otherwise checks that dout holds; irq checked every cycle.
    initial begin
        exp_t        e;
        logic [31:0] last0 = 32'd0;
        logic [31:0] last1 = 32'd0;
        forever begin
            @(negedge clock or rst_chk_ev);
            if (reset) begin
                chk("reset dout0", dout0, 32'd0);
                chk("reset dout1", dout1, 32'd0);
                chk("reset irq0", {31'd0, irq0}, 32'd0);
                chk("reset irq1", {31'd0, irq1}, 32'd0);
                last0 = 32'd0;
                last1 = 32'd0;
            end else begin
                chk("irq0", {31'd0, irq0}, {31'd0, m_irq[0]});
                chk("irq1", {31'd0, irq1}, {31'd0, m_irq[1]});
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    last0 = e.d0;
                    last1 = e.d1;
                    chk($sformatf("read0 @%h", e.a[7:0]), dout0, last0);
                    chk($sformatf("read1 @%h", e.a[7:0]), dout1, last1);
                    $display("[TB] read addr %h: dout0=%h dout1=%h", e.a[7:0], dout0, dout1);
                end else begin
                    chk("hold dout0", dout0, last0);
                    chk("hold dout1", dout1, last1);
                end
            end
        end
    end

    task automatic op(input bit s, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        sel = s; we = w; re = r; addr = a; din = d;
    endtask

    initial begin
        logic [31:0] ra, rd;
        sel = 0; we = 0; re = 0; addr = 0; din = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) op(1, 0, 1, 32'(i * 4), 0);
        op(1, 0, 1, 32'h30, 0);
        op(1, 0, 1, 32'h20, 0);

        // Channel 0 auto-reload with interrupt, then clear
        op(1, 1, 0, 32'h08, 3);
        op(1, 1, 0, 32'h00, 7);
        repeat (20) op(1, 0, 1, 32'h04, 0);
        op(1, 1, 0, 32'h0C, 1);
        repeat (3) op(1, 0, 1, 32'h0C, 0);
        repeat (6) op(1, 0, 1, 32'h04, 0);

        // Channel 1 one-shot without interrupt
        op(1, 1, 0, 32'h18, 2);
        op(1, 1, 0, 32'h10, 1);
        repeat (30) op(1, 0, 1, 32'h14, 0);
        op(1, 0, 1, 32'h10, 0);
        op(1, 0, 1, 32'h1C, 0);

        // Counter wrap through all-ones
        op(1, 1, 0, 32'h00, 0);
        op(1, 1, 0, 32'h0C, 1);
        op(1, 1, 0, 32'h08, 5);
        op(1, 1, 0, 32'h04, 32'hFFFF_FFFE);
        op(1, 1, 0, 32'h00, 1);
        repeat (16) begin
            op(1, 0, 1, 32'h04, 0);
            op(1, 0, 1, 32'h0C, 0);
        end

        // Bus write colliding with tick update, both prescaler phases
        op(1, 1, 0, 32'h00, 3);
        repeat (2) begin
            op(1, 1, 0, 32'h04, 32'h10);
            op(1, 0, 1, 32'h04, 0);
            op(0, 0, 0, 0, 0);
        end
        op(1, 1, 0, 32'h08, 0);
        op(1, 1, 0, 32'h04, 0);
        repeat (4) begin
            op(1, 1, 1, 32'h0C, 1);
            op(1, 0, 1, 32'h0C, 0);
        end

        // Read and write to the same register in one cycle
        op(1, 1, 1, 32'h18, 32'h55);
        op(1, 0, 1, 32'h18, 0);

        // Async reset between edges while counting
        op(1, 1, 0, 32'h00, 0);
        op(1, 1, 0, 32'h04, 32'h1234);
        op(1, 1, 0, 32'h00, 5);
        repeat (5) op(0, 0, 0, 0, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        #1 -> rst_chk_ev;
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) op(1, 0, 1, 32'(i * 4), 0);
        repeat (10) op(0, 0, 0, 0, 0);
        op(1, 0, 1, 32'h04, 0);
        op(1, 0, 1, 32'h00, 0);

        // Randomized traffic, including out-of-range channels and junk address bits
        repeat (600) begin
            ra = $urandom;
            ra[7:4] = 4'($urandom_range(0, 3));
            rd = ($urandom % 2 == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
            op(bit'($urandom % 4 != 0), bit'($urandom % 2), bit'($urandom % 2), ra, rd);
        end

        repeat (3) op(0, 0, 0, 0, 0);
        @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
